// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types and constants for the single-precision add/sub unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01
    } fpu_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } fpu_state_e;

    localparam int          EXP_BIAS = 127;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

endpackage
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fpu_lzc
// Description : Combinational 27-bit leading-zero counter (27 for all-zero).
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_lzc (
    input  logic [26:0] i_data,
    output logic [4:0]  o_count
);

    // Ascending scan: the most significant set bit is the last one to win.
    always_comb begin
        o_count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (i_data[i]) begin
                o_count = 5'(26 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub
// Description : Multi-cycle IEEE-754 single-precision add/sub, RNE, flush-to-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub
    import fpu_pkg::*;
#(
    parameter int FTZ = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  fpu_op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        invalid_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        inexact_o
);

    localparam logic c_ftz = (FTZ != 0);

    fpu_state_e  r_state, w_state_next;

    logic [31:0] r_a, r_b;
    logic        r_rsvd;
    logic        r_sign_l, r_eff_sub;
    logic [7:0]  r_exp_l;
    logic [26:0] r_man_l, r_man_s;
    logic        r_spec, r_spec_inv;
    logic [31:0] r_spec_res;
    logic [27:0] r_sum;
    logic [26:0] r_man_n;
    logic [9:0]  r_exp_n;
    logic        r_zero;
    logic [31:0] r_res;
    logic        r_inv, r_ovf, r_unf, r_inx;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_state_next = ALIGN;
            ALIGN:   w_state_next = ADD;
            ADD:     w_state_next = NORM;
            NORM:    w_state_next = ROUND;
            ROUND:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand classification and alignment
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_a_ge;
    logic [31:0] w_big, w_small;
    logic [7:0]  w_diff;
    logic [26:0] w_man_sm, w_mask, w_man_s;
    logic        w_spec, w_spec_inv;
    logic [31:0] w_spec_res;

    always_comb begin
        w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
        w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
        w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
        w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
        w_a_zero = (r_a[30:23] == 8'h00) && ((r_a[22:0] == 23'd0) || c_ftz);
        w_b_zero = (r_b[30:23] == 8'h00) && ((r_b[22:0] == 23'd0) || c_ftz);

        w_a_ge   = (r_a[30:0] >= r_b[30:0]);
        w_big    = w_a_ge ? r_a : r_b;
        w_small  = w_a_ge ? r_b : r_a;
        w_diff   = w_big[30:23] - w_small[30:23];
        w_man_sm = {1'b1, w_small[22:0], 3'b000};
        w_mask   = (27'd1 << w_diff) - 27'd1;
        if (w_diff >= 8'd27) begin
            w_man_s = 27'd1;
        end else begin
            w_man_s = (w_man_sm >> w_diff) | {26'd0, |(w_man_sm & w_mask)};
        end

        w_spec     = 1'b1;
        w_spec_inv = 1'b0;
        w_spec_res = QNAN;
        if (r_rsvd) begin
            w_spec_inv = 1'b1;
        end else if (w_a_nan || w_b_nan) begin
            w_spec_inv = (w_a_nan && !r_a[22]) || (w_b_nan && !r_b[22]);
        end else if (w_a_inf && w_b_inf) begin
            if (r_a[31] == r_b[31]) w_spec_res = r_a;
            else                    w_spec_inv = 1'b1;
        end else if (w_a_inf) begin
            w_spec_res = r_a;
        end else if (w_b_inf) begin
            w_spec_res = r_b;
        end else if (w_a_zero && w_b_zero) begin
            w_spec_res = {r_a[31] & r_b[31], 31'd0};
        end else if (w_a_zero) begin
            w_spec_res = r_b;
        end else if (w_b_zero) begin
            w_spec_res = r_a;
        end else begin
            w_spec = 1'b0;
        end
    end

    logic [4:0] w_lz;

    fpu_lzc u_lzc (
        .i_data  (r_sum[26:0]),
        .o_count (w_lz)
    );

    // Rounding: bits [2:0] of the normalised mantissa are guard/round/sticky
    logic        w_rnd_up, w_inexact, w_exp_le0, w_ovf;
    logic [24:0] w_mant_r;
    logic [9:0]  w_exp_r;
    logic [22:0] w_frac_r;

    always_comb begin
        w_rnd_up  = r_man_n[2] & (r_man_n[1] | r_man_n[0] | r_man_n[3]);
        w_inexact = |r_man_n[2:0];
        w_mant_r  = {1'b0, r_man_n[26:3]} + {24'd0, w_rnd_up};
        w_exp_r   = r_exp_n + {9'd0, w_mant_r[24]};
        w_frac_r  = w_mant_r[24] ? w_mant_r[23:1] : w_mant_r[22:0];
        w_exp_le0 = r_exp_n[9] || (r_exp_n == 10'd0);
        w_ovf     = !w_exp_r[9] && (w_exp_r >= 10'd255);
    end

    always_ff @(posedge clk_i) begin
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    r_a    <= op_a_i;
                    r_b    <= op_b_i ^ {(fpu_op_i == OP_SUB), 31'd0};
                    r_rsvd <= fpu_op_i[1];
                    r_inv  <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_unf  <= 1'b0;
                    r_inx  <= 1'b0;
                end
            end
            ALIGN: begin
                r_sign_l   <= w_big[31];
                r_exp_l    <= w_big[30:23];
                r_man_l    <= {1'b1, w_big[22:0], 3'b000};
                r_man_s    <= w_man_s;
                r_eff_sub  <= r_a[31] ^ r_b[31];
                r_spec     <= w_spec;
                r_spec_inv <= w_spec_inv;
                r_spec_res <= w_spec_res;
            end
            ADD: begin
                r_sum <= r_eff_sub ? ({1'b0, r_man_l} - {1'b0, r_man_s})
                                   : ({1'b0, r_man_l} + {1'b0, r_man_s});
            end
            NORM: begin
                r_zero <= (r_sum == 28'd0);
                if (r_sum[27]) begin
                    r_man_n <= {r_sum[27:2], r_sum[1] | r_sum[0]};
                    r_exp_n <= {2'b00, r_exp_l} + 10'd1;
                end else begin
                    // Keep the sticky bit alive when shifting left after a borrow
                    r_man_n <= (r_sum[26:0] << w_lz) | {26'd0, r_sum[0]};
                    r_exp_n <= {2'b00, r_exp_l} - {5'd0, w_lz};
                end
            end
            ROUND: begin
                r_inv <= 1'b0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
                r_inx <= 1'b0;
                if (r_spec) begin
                    r_res <= r_spec_res;
                    r_inv <= r_spec_inv;
                end else if (r_zero) begin
                    r_res <= 32'd0;
                end else if (w_exp_le0) begin
                    r_res <= {r_sign_l, 31'd0};
                    r_unf <= 1'b1;
                    r_inx <= 1'b1;
                end else if (w_ovf) begin
                    r_res <= POS_INF | {r_sign_l, 31'd0};
                    r_ovf <= 1'b1;
                    r_inx <= 1'b1;
                end else begin
                    r_res <= {r_sign_l, w_exp_r[7:0], w_frac_r};
                    r_inx <= w_inexact;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            valid_o     <= 1'b0;
            result_o    <= 32'd0;
            invalid_o   <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            valid_o <= (r_state == DONE);
            if (r_state == DONE) begin
                result_o    <= r_res;
                invalid_o   <= r_inv;
                overflow_o  <= r_ovf;
                underflow_o <= r_unf;
                inexact_o   <= r_inx;
            end
        end
    end

    assign busy_o = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_addsub
// Description : Scoreboard bench for fpu_addsub with an exact-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub;
    import fpu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i = 1'b0;
    logic [1:0]  fpu_op_i = 2'b00;
    logic [31:0] op_a_i = 32'd0;
    logic [31:0] op_b_i = 32'd0;
    logic        busy_o, valid_o, invalid_o, overflow_o, underflow_o, inexact_o;
    logic [31:0] result_o;

    fpu_addsub #(.FTZ(1)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .fpu_op_i    (fpu_op_i),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .invalid_o   (invalid_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .inexact_o   (inexact_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected response: result then flags {invalid, overflow, underflow, inexact}
    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h, required %h", name, act, req);
        end
    endtask

    // Exact value of each operand as an integer times a power of two, then RNE to 24 bits.
    function automatic exp_t ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b_in);
        logic [31:0]  b;
        logic         sa, sb, sr, inv;
        bit           a_nan, b_nan, a_inf, b_inf, inx;
        int           ea, eb, emin, p, e_res, sh;
        logic [299:0] ra, rb, rs, kept, rem, half;
        b = b_in;
        if (op[1]) return {QNAN, 4'b1000};
        if (op == 2'b01) b[31] = ~b[31];
        sa = a[31];
        sb = b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        a_nan = (ea == 255) && (a[22:0] != 23'd0);
        b_nan = (eb == 255) && (b[22:0] != 23'd0);
        a_inf = (ea == 255) && (a[22:0] == 23'd0);
        b_inf = (eb == 255) && (b[22:0] == 23'd0);
        if (a_nan || b_nan) begin
            inv = (a_nan && !a[22]) || (b_nan && !b[22]);
            return {QNAN, inv, 3'b000};
        end
        if (a_inf && b_inf) return (sa == sb) ? {a, 4'b0000} : {QNAN, 4'b1000};
        if (a_inf) return {a, 4'b0000};
        if (b_inf) return {b, 4'b0000};
        if (ea == 0 && eb == 0) return {sa & sb, 31'd0, 4'b0000};
        if (ea == 0) return {b, 4'b0000};
        if (eb == 0) return {a, 4'b0000};

        emin = (ea < eb) ? ea : eb;
        ra = 300'({1'b1, a[22:0]}) << (ea - emin);
        rb = 300'({1'b1, b[22:0]}) << (eb - emin);
        if (sa == sb)      begin rs = ra + rb; sr = sa; end
        else if (ra >= rb) begin rs = ra - rb; sr = sa; end
        else               begin rs = rb - ra; sr = sb; end
        if (rs == 300'd0) return 36'd0;

        p = 0;
        for (int i = 0; i < 300; i++) if (rs[i]) p = i;
        e_res = p + emin - 23;
        if (e_res <= 0) return {sr, 31'd0, 4'b0011};
        if (p >= 23) begin
            sh   = p - 23;
            kept = rs >> sh;
            rem  = rs & ((300'd1 << sh) - 300'd1);
            half = (sh == 0) ? 300'd0 : (300'd1 << (sh - 1));
            inx  = (rem != 300'd0);
            if (rem > half || (rem == half && inx && kept[0])) kept = kept + 300'd1;
        end else begin
            kept = rs << (23 - p);
            inx  = 1'b0;
        end
        if (kept[24]) begin
            kept  = kept >> 1;
            e_res = e_res + 1;
        end
        if (e_res >= 255) return {sr, 8'hFF, 23'd0, 4'b0101};
        return {sr, 8'(e_res), kept[22:0], 3'b000, inx};
    endfunction

    // Monitor: every valid_o must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        exp_t e;
        if (valid_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: actual valid_o=1, required no pending result");
            end else begin
                e = sb_q.pop_front();
                check("result", 64'(result_o), 64'(e.res));
                check("flags", 64'({invalid_o, overflow_o, underflow_o, inexact_o}), 64'(e.flags));
            end
        end
    end

    // Issue one operation and check the busy/valid timeline over the 6 samples after capture
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input bit glitch);
        logic [5:0] busy_v, valid_v;
        sb_q.push_back(e);
        @(negedge clk_i);
        start_i  = 1'b1;
        fpu_op_i = op;
        op_a_i   = a;
        op_b_i   = b;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i);
            #1;
            if (k == 0) begin
                start_i = 1'b0;
                op_a_i  = $urandom;
                op_b_i  = $urandom;
            end
            busy_v[k]  = busy_o;
            valid_v[k] = valid_o;
            if (glitch && k == 1) begin
                start_i  = 1'b1;
                fpu_op_i = 2'b11;
            end
            if (glitch && k == 2) start_i = 1'b0;
        end
        check("busy_timeline", 64'(busy_v), 64'(6'b011111));
        check("valid_timeline", 64'(valid_v), 64'(6'b100000));
    endtask

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] f;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom_range(0, 15))
            0:       return {s, 8'hFF, 23'd0};
            1:       return {s, 8'hFF, f | 23'd1};
            2:       return {s, 31'd0};
            3:       return {s, 8'h00, f | 23'd1};
            4:       return {s, 8'hFE, f};
            5:       return {s, 8'h01, f};
            default: return {s, 8'($urandom_range(1, 254)), f};
        endcase
    endfunction

    function automatic logic [31:0] near_fp(input logic [31:0] a, input int spread);
        int e;
        e = int'(a[30:23]) + int'($urandom_range(0, 2 * spread)) - spread;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    logic [1:0]  d_op [14] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0,
                               2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd0};
    logic [31:0] d_a  [14] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                               32'h7F7FFFFF, 32'h12345678, 32'h7FA00000, 32'h7FC00001,
                               32'hFF800000, 32'h00800000, 32'h3F800000, 32'h3F800000,
                               32'h3F800000, 32'h3F800001};
    logic [31:0] d_b  [14] = '{32'h40000000, 32'h3F800000, 32'h33800000, 32'h7F800000,
                               32'h7F7FFFFF, 32'h9ABCDEF0, 32'h3F800000, 32'h3F800000,
                               32'h3F800000, 32'h00800001, 32'h3F800000, 32'hBF800000,
                               32'h33800000, 32'h33800000};
    logic [31:0] d_r  [14] = '{32'h40400000, 32'h00000000, 32'h3F800000, 32'h7FC00000,
                               32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                               32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h00000000,
                               32'h3F7FFFFF, 32'h3F800002};
    logic [3:0]  d_f  [14] = '{4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0101, 4'b1000, 4'b1000,
                               4'b0000, 4'b0000, 4'b0011, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        rst_ni = 1'b1;
        #2 rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("reset_state", 64'({busy_o, valid_o, result_o, invalid_o, overflow_o, underflow_o, inexact_o}), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_op(d_op[i], d_a[i], d_b[i], {d_r[i], d_f[i]}, i == 2);
        end

        // Abort an operation in NORM; its result must never appear
        @(negedge clk_i);
        start_i  = 1'b1;
        fpu_op_i = 2'b00;
        op_a_i   = 32'h40490FDB;
        op_b_i   = 32'h3F800000;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
        end
        rst_ni = 1'b0;
        #1;
        check("reset_abort", 64'({busy_o, valid_o, result_o, invalid_o, overflow_o, underflow_o, inexact_o}), 64'd0);
        @(posedge clk_i);
        #1;
        check("reset_hold", 64'({busy_o, valid_o, result_o}), 64'd0);
        rst_ni = 1'b1;
        run_op(2'b00, 32'h3F800000, 32'h40000000, {32'h40400000, 4'b0000}, 1'b0);

        for (int n = 0; n < 250; n++) begin
            a = rand_fp();
            case ($urandom_range(0, 4))
                0:       b = rand_fp();
                1:       b = near_fp(a, 2);
                2:       b = near_fp(a, 30);
                3:       b = {1'($urandom), a[30:1], 1'($urandom)};
                default: b = near_fp(a, 0);
            endcase
            op = ($urandom_range(0, 19) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
            run_op(op, a, b, ref_model(op, a, b), 1'b0);
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpu_addsub.md
FPU_ADDSUB -- requirements
Module: fpu_addsub

Interface
REQ-001 Parameter FTZ, default 1, meaning: subnormal inputs and outputs are flushed to signed zero; only value 1 is supported.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset; asynchronous, active-low.
REQ-004 start_i  in  1  request; driven from the decoder FPU enable.
REQ-005 fpu_op_i  in  2  operation: 00 add, 01 sub (a-b), 10/11 reserved.
REQ-006 op_a_i  in  32  IEEE-754 single-precision operand A.
REQ-007 op_b_i  in  32  IEEE-754 single-precision operand B.
REQ-008 busy_o  out  1  high while an operation is in flight; used by core to stall.
REQ-009 valid_o  out  1  one-cycle pulse when result_o/flags are updated.
REQ-010 result_o  out  32  single-precision result; held until next valid_o.
REQ-011 invalid_o, overflow_o, underflow_o, inexact_o  out  1 each  exception flags; valid with valid_o, held with result_o.

Function
REQ-012 FSM states IDLE, ALIGN, ADD, NORM, ROUND, DONE; transitions IDLE->ALIGN on start_i, then one state per cycle, DONE->IDLE unconditionally.
REQ-013 Operands and fpu_op_i are captured only in IDLE with start_i=1; start_i in any other state is ignored.
REQ-014 Latency fixed at 5 cycles for all inputs: start_i sampled at edge N, valid_o high in the cycle after edge N+5.
REQ-015 busy_o high in ALIGN, ADD, NORM, ROUND and DONE; low in IDLE.
REQ-016 Sub: sign of B inverted at capture; reserved op: result 0x7FC00000, invalid_o=1, normal latency.
REQ-017 ALIGN: swap so |A|>=|B|; right-shift smaller mantissa (hidden bit restored) by exponent difference; shifts >=27 collapse to sticky only.
REQ-018 ADD: 27-bit mantissa add or subtract (hidden + 23 + guard/round/sticky, plus carry bit) per effective operation.
REQ-019 NORM: carry-out -> shift right 1, exponent+1, sticky OR; otherwise left shift by leading-zero count, exponent decremented by it.
REQ-020 ROUND: round-to-nearest-even from guard/round/sticky; mantissa carry-out re-normalises; inexact_o = G|R|S.
REQ-021 Exponent >=255 after rounding -> signed Inf, overflow_o=1, inexact_o=1.
REQ-022 Exponent <=0 after normalisation -> signed zero, underflow_o=1, inexact_o=1 (FTZ).
REQ-023 Exact cancellation (x-x) -> +0x00000000, no flags.
REQ-024 Any NaN input -> 0x7FC00000; invalid_o=1 only if a NaN input is signalling (bit22=0).
REQ-025 Inf+(-Inf) -> 0x7FC00000, invalid_o=1; Inf with finite -> that Inf, no flags.
REQ-026 Special cases (NaN/Inf/zero/subnormal) detected in ALIGN, result forced in ROUND, keeping fixed latency.
REQ-027 Flags cleared at each capture; set only as specified.

Reset
REQ-028 rst_ni low: FSM to IDLE immediately; busy_o, valid_o, all flags 0; result_o 0x00000000.
REQ-029 Reset mid-operation aborts it; no valid_o is produced for the aborted request.
REQ-030 First start_i honoured on the first rising edge after rst_ni deasserts.

Structure
REQ-031 Shared package fpu_pkg holds fpu_op enum (ADD=00, SUB=01), FSM state enum, constants EXP_BIAS=127, QNAN=0x7FC00000, POS_INF=0x7F800000.
REQ-032 One sub-module fpu_lzc: combinational 27-bit leading-zero counter, 5-bit output, used by NORM.
REQ-033 Datapath registers between FSM stages only; no combinational path from inputs to outputs.

Verification
REQ-034 add 0x3F800000+0x40000000 -> result 0x40400000, no flags, valid_o exactly 5 cycles after start, busy_o high for 5 cycles.
REQ-035 sub 0x3F800000-0x3F800000 -> 0x00000000, no flags; add 0x3F800000+0x33800000 -> 0x3F800000, inexact_o=1 (tie to even).
REQ-036 sub 0x7F800000-0x7F800000 -> 0x7FC00000, invalid_o=1; add 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow_o=1, inexact_o=1.
REQ-037 fpu_op_i=10 with any operands -> 0x7FC00000, invalid_o=1; add 0x7FA00000+0x3F800000 -> 0x7FC00000, invalid_o=1.
REQ-038 Second start_i pulsed during busy -> ignored, exactly one valid_o; rst_ni low in NORM -> outputs zero, no valid_o, next op correct.
